seq_divider: RTL

//  Iterative restoring divider for the HighSpeed arithmetic library. It is the inverse

---
 rtl/seq_divider_if.sv | 22 ++
 rtl/seq_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between a divider client and seq_divider.
// master: the requesting side; slave: the divider.
interface seq_divider_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Optional SEQ_DIVIDER_SIGNED_EN: two's complement operands with one sign fix-up cycle.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | shift-subtract-restore iterations, WIDTH edges
// FIX    | sign correction of magnitude results (signed build only)
// ZDIV   | divide-by-zero result staging, RUN skipped
// DONE   | one-cycle done pulse; start accepted here as from IDLE
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_ZDIV,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             zero_in;
  logic             last_iter;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] z_rem;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // MIN negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    q_fix = q_neg_q ? -q_q : q_q;
    r_fix = r_neg_q ? -r_q : r_q;
    z_rem = r_neg_q ? -q_q : q_q;
  end
`else
  always_comb begin
    a_mag = bus.dividend;
    b_mag = bus.divisor;
    z_rem = q_q;
  end
`endif

  assign zero_in   = (bus.divisor == '0);
  assign accept    = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // R stays below the divisor, so the shifted value always fits in WIDTH+1 bits.
  always_comb begin
    r_sh   = {r_q, q_q[WIDTH-1]};
    t      = r_sh - {1'b0, dvs_q};
    q_step = {q_q[WIDTH-2:0], ~t[WIDTH]};
    r_step = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = zero_in ? S_ZDIV : S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (last_iter) state_nxt = S_FIX;
`else
        if (last_iter) state_nxt = S_DONE;
`endif
      end
      S_FIX: begin
        bus.busy  = 1'b1;
        state_nxt = S_DONE;
      end
      S_ZDIV: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (accept) state_nxt = zero_in ? S_ZDIV : S_RUN;
        else        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q             <= '0;
      q_q             <= '0;
      dvs_q           <= '0;
      cnt_q           <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q         <= 1'b0;
      r_neg_q         <= 1'b0;
`endif
    end else if (accept) begin
      r_q   <= '0;
      q_q   <= a_mag;
      dvs_q <= b_mag;
      cnt_q <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg_q <= bus.dividend[WIDTH-1];
`endif
    end else begin
      case (state)
        S_RUN: begin
          r_q   <= r_step;
          q_q   <= q_step;
          cnt_q <= cnt_q + 1'b1;
`ifndef SEQ_DIVIDER_SIGNED_EN
          if (last_iter) begin
            bus.quotient    <= q_step;
            bus.remainder   <= r_step;
            bus.div_by_zero <= 1'b0;
          end
`endif
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        S_FIX: begin
          bus.quotient    <= q_fix;
          bus.remainder   <= r_fix;
          bus.div_by_zero <= 1'b0;
        end
`endif
        S_ZDIV: begin
          bus.quotient    <= '1;
          bus.remainder   <= z_rem;
          bus.div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
